// File: rtl/rtp_audio_packer.sv
// rtp_audio_packer
// Packs multi-channel PCM frames into RTP packets and streams them out as
// bytes. Two banks of SAMPLES_PER_PKT frames fill alternately. A full bank is
// sent as a 12-byte RTP header followed by its payload. A frame that arrives
// while its target bank is still waiting to go out is dropped and counted.
//
// Ports
//   clk, rst_n        : clock and synchronous active-low reset
//   in_data/in_valid  : one frame per strobe, channel 0 in the LSBs, no ready
//   out_data/out_valid/out_ready/out_last : packet byte stream
//   out_length        : constant packet length in bytes
//   overrun           : sticky drop flag, cleared by clr_overrun
//   overrun_cnt       : saturating count of dropped frames
module rtp_audio_packer #(
  parameter int unsigned CHANNELS        = 2,
  parameter int unsigned SAMPLE_W        = 16,
  parameter int unsigned SAMPLES_PER_PKT = 240,
  parameter logic [15:0] RTP_HDR         = 16'h8080,
  parameter logic [31:0] SSRC            = 32'h12345678
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CHANNELS*SAMPLE_W-1:0] in_data,
  input  logic                         in_valid,
  output logic [7:0]                   out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic [15:0]                  out_length,
  output logic                         overrun,
  input  logic                         clr_overrun,
  output logic [15:0]                  overrun_cnt
);

  localparam int unsigned FRAME_W = CHANNELS * SAMPLE_W;
  localparam int unsigned BPS     = SAMPLE_W / 8;
  localparam int unsigned PKT_LEN = 12 + CHANNELS * SAMPLES_PER_PKT * BPS;
  localparam int unsigned IDX_W   = $clog2(SAMPLES_PER_PKT);
  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned BY_W    = (BPS > 1) ? $clog2(BPS) : 1;
  localparam int unsigned CNT_W   = $clog2(PKT_LEN + 1);
  localparam int unsigned SH_W    = $clog2(FRAME_W) + 1;

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY} state_t;

  logic [FRAME_W-1:0] mem_q [0:1][0:SAMPLES_PER_PKT-1];

  state_t            state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [1:0]        full_q, full_d;
  logic [31:0]       ts_q, ts_d;
  logic [1:0][31:0]  bank_ts_q, bank_ts_d;
  logic              tx_bank_q, tx_bank_d;
  logic [15:0]       seq_q, seq_d;
  logic              marker_pend_q, marker_pend_d;
  logic              marker_q, marker_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;   // index of the next byte to load
  logic [IDX_W-1:0]  pf_q, pf_d;     // payload frame
  logic [CH_W-1:0]   pc_q, pc_d;     // payload channel
  logic [BY_W-1:0]   pb_q, pb_d;     // payload byte within sample, MSB first
  logic [7:0]        out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              overrun_q, overrun_d;
  logic [15:0]       ovr_cnt_q, ovr_cnt_d;

  logic              hs_s, release_s, wr_free_s, wr_en_s, drop_s, load_s;
  logic [7:0]        hdr_byte_s, pay_byte_s;
  logic [FRAME_W-1:0] rd_frame_s, sh_frame_s;
  logic [SH_W-1:0]   shamt_s;

  assign hs_s      = out_valid_q && out_ready;
  assign release_s = hs_s && out_last_q;
  // A bank released this cycle can take the incoming frame immediately.
  assign wr_free_s = !full_q[wr_bank_q] || (release_s && (tx_bank_q == wr_bank_q));
  assign wr_en_s   = in_valid && wr_free_s;
  assign drop_s    = in_valid && !wr_free_s;
  // Output register is a one-deep prefetch: refill when empty or draining.
  assign load_s    = (state_q != S_IDLE) && (cnt_q != CNT_W'(PKT_LEN))
                     && (!out_valid_q || out_ready);

  // Header byte selection by byte index
  always_comb begin
    hdr_byte_s = 8'h00;
    case (cnt_q[3:0])
      4'd0:    hdr_byte_s = RTP_HDR[15:8];
      4'd1:    hdr_byte_s = {marker_q, RTP_HDR[6:0]};
      4'd2:    hdr_byte_s = seq_q[15:8];
      4'd3:    hdr_byte_s = seq_q[7:0];
      4'd4:    hdr_byte_s = bank_ts_q[tx_bank_q][31:24];
      4'd5:    hdr_byte_s = bank_ts_q[tx_bank_q][23:16];
      4'd6:    hdr_byte_s = bank_ts_q[tx_bank_q][15:8];
      4'd7:    hdr_byte_s = bank_ts_q[tx_bank_q][7:0];
      4'd8:    hdr_byte_s = SSRC[31:24];
      4'd9:    hdr_byte_s = SSRC[23:16];
      4'd10:   hdr_byte_s = SSRC[15:8];
      4'd11:   hdr_byte_s = SSRC[7:0];
      default: hdr_byte_s = 8'h00;
    endcase
  end

  assign rd_frame_s = mem_q[tx_bank_q][pf_q];
  assign shamt_s    = SH_W'(pc_q) * SH_W'(SAMPLE_W) + SH_W'(pb_q) * SH_W'(8);
  assign sh_frame_s = rd_frame_s >> shamt_s;
  assign pay_byte_s = sh_frame_s[7:0];

  // Next-state logic: writer, transmitter FSM, output register, overrun
  always_comb begin
    state_d       = state_q;
    wr_bank_d     = wr_bank_q;
    wr_idx_d      = wr_idx_q;
    full_d        = full_q;
    ts_d          = ts_q;
    bank_ts_d     = bank_ts_q;
    tx_bank_d     = tx_bank_q;
    seq_d         = seq_q;
    marker_pend_d = marker_pend_q;
    marker_d      = marker_q;
    cnt_d         = cnt_q;
    pf_d          = pf_q;
    pc_d          = pc_q;
    pb_d          = pb_q;
    out_data_d    = out_data_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    overrun_d     = overrun_q;
    ovr_cnt_d     = ovr_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (full_q[tx_bank_q]) begin
          state_d       = S_HDR;
          marker_d      = marker_pend_q;
          marker_pend_d = 1'b0;
          cnt_d         = '0;
          pf_d          = '0;
          pc_d          = '0;
          pb_d          = BY_W'(BPS - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HDR: begin
        if (load_s && (cnt_q == CNT_W'(11))) state_d = S_PAY;
        else                                  state_d = S_HDR;
      end
      S_PAY: begin
        if (release_s) begin
          state_d            = S_IDLE;
          full_d[tx_bank_q]  = 1'b0;
          tx_bank_d          = ~tx_bank_q;
          seq_d              = seq_q + 16'd1;
        end else begin
          state_d = S_PAY;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load_s) begin
      out_valid_d = 1'b1;
      out_last_d  = (cnt_q == CNT_W'(PKT_LEN - 1));
      out_data_d  = (cnt_q < CNT_W'(12)) ? hdr_byte_s : pay_byte_s;
      cnt_d       = cnt_q + CNT_W'(1);
      if (cnt_q >= CNT_W'(12)) begin
        if (pb_q == '0) begin
          pb_d = BY_W'(BPS - 1);
          if (pc_q == CH_W'(CHANNELS - 1)) begin
            pc_d = '0;
            pf_d = pf_q + IDX_W'(1);
          end else begin
            pc_d = pc_q + CH_W'(1);
          end
        end else begin
          pb_d = pb_q - BY_W'(1);
        end
      end else begin
        pb_d = pb_q;
      end
    end else if (hs_s) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    // ts counts every strobe, dropped frames included.
    if (in_valid) ts_d = ts_q + 32'd1;
    else          ts_d = ts_q;

    if (wr_en_s) begin
      if (wr_idx_q == '0) bank_ts_d[wr_bank_q] = ts_q;
      else                bank_ts_d[wr_bank_q] = bank_ts_q[wr_bank_q];
      if (wr_idx_q == IDX_W'(SAMPLES_PER_PKT - 1)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_idx_d          = '0;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_idx_d = wr_idx_q + IDX_W'(1);
      end
    end else begin
      wr_idx_d = wr_idx_q;
    end

    // A drop wins over both clr_overrun and the marker clear on entering HDR.
    if (drop_s) begin
      overrun_d     = 1'b1;
      marker_pend_d = 1'b1;
      if (ovr_cnt_q != 16'hFFFF) ovr_cnt_d = ovr_cnt_q + 16'd1;
      else                       ovr_cnt_d = ovr_cnt_q;
    end else if (clr_overrun) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Frame storage write port
  always_ff @(posedge clk) begin
    if (wr_en_s) mem_q[wr_bank_q][wr_idx_q] <= in_data;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      wr_bank_q     <= 1'b0;
      wr_idx_q      <= '0;
      full_q        <= 2'b00;
      ts_q          <= 32'd0;
      bank_ts_q     <= '0;
      tx_bank_q     <= 1'b0;
      seq_q         <= 16'd0;
      marker_pend_q <= 1'b1;
      marker_q      <= 1'b0;
      cnt_q         <= '0;
      pf_q          <= '0;
      pc_q          <= '0;
      pb_q          <= '0;
      out_data_q    <= 8'h00;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      overrun_q     <= 1'b0;
      ovr_cnt_q     <= 16'd0;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      wr_idx_q      <= wr_idx_d;
      full_q        <= full_d;
      ts_q          <= ts_d;
      bank_ts_q     <= bank_ts_d;
      tx_bank_q     <= tx_bank_d;
      seq_q         <= seq_d;
      marker_pend_q <= marker_pend_d;
      marker_q      <= marker_d;
      cnt_q         <= cnt_d;
      pf_q          <= pf_d;
      pc_q          <= pc_d;
      pb_q          <= pb_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      overrun_q     <= overrun_d;
      ovr_cnt_q     <= ovr_cnt_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign out_length  = 16'(PKT_LEN);
  assign overrun     = overrun_q;
  assign overrun_cnt = ovr_cnt_q;

endmodule

// File: tb/tb_rtp_audio_packer.sv
// tb_rtp_audio_packer
// Directed bench for rtp_audio_packer with CHANNELS=2, SAMPLE_W=16,
// SAMPLES_PER_PKT=4 (28-byte packets). Frame t carries ch0=16'h1100+t and
// ch1=16'h2200+t, so each packet payload is derived from its timestamp.
module tb_rtp_audio_packer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_valid = 1'b0;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic [15:0] out_length;
  logic        overrun;
  logic        clr_overrun = 1'b0;
  logic [15:0] overrun_cnt;

  int n_chk = 0;
  int n_bad = 0;
  int ready_mode = 0;   // 0 hold low, 1 hold high, 2 random 30% low
  int stall_bad = 0;
  int gap_bad = 0;
  int cyc = 0;
  int bidx = 0;
  int start_cyc = 0;
  logic       stall_v = 1'b0;
  logic [7:0] stall_d = 8'h00;
  logic       stall_l = 1'b0;
  logic       after_last = 1'b0;
  logic [7:0] bq [$];
  logic       lq [$];
  int         sq [$];

  always #5 clk = ~clk;

  rtp_audio_packer #(
    .CHANNELS(2), .SAMPLE_W(16), .SAMPLES_PER_PKT(4),
    .RTP_HDR(16'h8080), .SSRC(32'h12345678)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_length(out_length), .overrun(overrun),
    .clr_overrun(clr_overrun), .overrun_cnt(overrun_cnt)
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sink side: drive out_ready, capture handshakes, watch stall stability and gaps.
  always @(negedge clk) begin
    cyc++;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = ($urandom_range(0, 9) >= 3);
    endcase
    if (!rst_n) begin
      stall_v = 1'b0; bidx = 0; after_last = 1'b0;
    end else begin
      if (stall_v && (!out_valid || out_data !== stall_d || out_last !== stall_l)) stall_bad++;
      if (after_last && out_valid) gap_bad++;
      after_last = 1'b0;
      stall_v = out_valid && !out_ready;
      stall_d = out_data;
      stall_l = out_last;
      if (out_valid && out_ready) begin
        if (bidx == 0) start_cyc = cyc;
        bq.push_back(out_data);
        lq.push_back(out_last);
        bidx++;
        if (out_last) begin
          sq.push_back(cyc - start_cyc + 1);
          bidx = 0;
          after_last = 1'b1;
        end
      end
    end
  end

  task automatic send_frame(input logic [31:0] t);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = {8'h22, t[7:0], 8'h11, t[7:0]};
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_pkt(input string tag, input logic [15:0] eseq, input logic [31:0] ets,
                           input logic em, input logic chk_span);
    logic [7:0]   b [28];
    logic [27:0]  lv;
    logic [127:0] pay_o, pay_e;
    logic [31:0]  f;
    int span;
    int waited = 0;
    while (bq.size() < 28 && waited < 600) begin
      @(negedge clk);
      waited++;
    end
    if (bq.size() < 28) begin
      check_eq({tag, "_timeout"}, bq.size(), 28);
      return;
    end
    for (int i = 0; i < 28; i++) begin
      b[i]  = bq.pop_front();
      lv[i] = lq.pop_front();
    end
    span = (sq.size() > 0) ? sq.pop_front() : 0;
    check_eq({tag, "_hdr0"}, b[0], 8'h80);
    check_eq({tag, "_m"}, b[1], {em, 7'h00});
    check_eq({tag, "_seq"}, {b[2], b[3]}, eseq);
    check_eq({tag, "_ts"}, {b[4], b[5], b[6], b[7]}, ets);
    check_eq({tag, "_ssrc"}, {b[8], b[9], b[10], b[11]}, 32'h12345678);
    pay_o = '0;
    pay_e = '0;
    for (int i = 0; i < 16; i++) pay_o = {pay_o[119:0], b[12+i]};
    for (int k = 0; k < 4; k++) begin
      f = ets + k;
      pay_e = {pay_e[95:0], 8'h11, f[7:0], 8'h22, f[7:0]};
    end
    check_eq({tag, "_pay"}, pay_o, pay_e);
    check_eq({tag, "_last"}, lv, 28'h8000000);
    if (chk_span) check_eq({tag, "_span"}, span, 28);
  endtask

  initial begin
    bit found;
    repeat (3) @(negedge clk);
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_last", out_last, 1'b0);
    check_eq("rst_data", out_data, 8'h00);
    check_eq("rst_ovr", overrun, 1'b0);
    check_eq("rst_ovr_cnt", overrun_cnt, 16'd0);
    check_eq("out_length", out_length, 16'd28);
    rst_n = 1'b1;
    ready_mode = 1;

    // Basic packet with latency
    for (int t = 0; t < 4; t++) send_frame(t);
    check_eq("lat_n", out_valid, 1'b0);
    @(negedge clk);
    check_eq("lat_n1", out_valid, 1'b0);
    @(negedge clk);
    check_eq("lat_n2_valid", out_valid, 1'b1);
    check_eq("lat_n2_data", out_data, 8'h80);
    check_pkt("basic", 16'd0, 32'd0, 1'b1, 1'b1);

    // Continuous stream
    for (int t = 4; t < 12; t++) send_frame(t);
    check_pkt("cont1", 16'd1, 32'd4, 1'b0, 1'b1);
    check_pkt("cont2", 16'd2, 32'd8, 1'b0, 1'b1);
    check_eq("cont_ovr_cnt", overrun_cnt, 16'd0);

    // Random back-pressure
    ready_mode = 2;
    for (int t = 12; t < 20; t++) send_frame(t);
    check_pkt("rnd1", 16'd3, 32'd12, 1'b0, 1'b0);
    check_pkt("rnd2", 16'd4, 32'd16, 1'b0, 1'b0);
    check_eq("rnd_ovr_cnt", overrun_cnt, 16'd0);

    // Back-pressure and overrun
    ready_mode = 0;
    for (int t = 20; t < 30; t++) send_frame(t);
    check_eq("bp_ovr", overrun, 1'b1);
    check_eq("bp_ovr_cnt", overrun_cnt, 16'd2);
    @(negedge clk);
    in_valid = 1'b1; clr_overrun = 1'b1; in_data = {8'h22, 8'd30, 8'h11, 8'd30};
    @(negedge clk);
    in_valid = 1'b0; clr_overrun = 1'b0;
    check_eq("clr_drop_ovr", overrun, 1'b1);
    check_eq("clr_drop_cnt", overrun_cnt, 16'd3);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check_eq("clr_ovr", overrun, 1'b0);
    check_eq("clr_cnt", overrun_cnt, 16'd3);

    // Release of bank coincides with a new frame
    ready_mode = 1;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (out_valid && out_last) found = 1'b1;
    end
    check_eq("rel_wait", found, 1'b1);
    in_valid = 1'b1;
    in_data  = {8'h22, 8'd31, 8'h11, 8'd31};
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("rel_ovr_cnt", overrun_cnt, 16'd3);
    check_eq("rel_ovr", overrun, 1'b0);
    for (int t = 32; t < 35; t++) send_frame(t);
    check_pkt("bp1", 16'd5, 32'd20, 1'b0, 1'b0);
    check_pkt("bp2", 16'd6, 32'd24, 1'b1, 1'b1);
    check_pkt("bp3", 16'd7, 32'd31, 1'b0, 1'b1);

    // Sequence wrap
    @(negedge clk);
    force dut.seq_q = 16'hFFFF;
    @(negedge clk);
    release dut.seq_q;
    for (int t = 35; t < 43; t++) send_frame(t);
    check_pkt("wrap1", 16'hFFFF, 32'd35, 1'b0, 1'b1);
    check_pkt("wrap2", 16'h0000, 32'd39, 1'b0, 1'b1);

    // Reset in the middle of a packet
    for (int t = 43; t < 47; t++) send_frame(t);
    for (int i = 0; i < 200 && bq.size() < 5; i++) @(posedge clk);
    check_eq("mid_wait", bq.size() >= 5, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_valid", out_valid, 1'b0);
    check_eq("mid_rst_cnt", overrun_cnt, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bq.delete(); lq.delete(); sq.delete();
    for (int t = 0; t < 4; t++) send_frame(t);
    check_pkt("post_rst", 16'd0, 32'd0, 1'b1, 1'b1);

    check_eq("stall_stable", stall_bad, 0);
    check_eq("gap_idle", gap_bad, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
    $fatal(1);
  end

endmodule
